// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned HALF_BIT   = 8;
  localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with pointers, occupancy count and a registered head byte.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Pop only when data is present; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    do_pop   = pop && valid;
    do_push  = push && (!full || do_pop);
    rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = count;
    if (do_push && !do_pop) begin
      count_n = count + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_n = count - (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count and the registered head byte. The head is looked up at the
  // post-update read pointer, bypassing the write data when that slot is being filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (count_n != '0) begin
        head <= (do_push && (rd_ptr_n == wr_ptr)) ? wr_data : mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver: synchronizer, tick generator, frame FSM, receive FIFO.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  input  logic [31:0] baud_divisor,
  input  logic [1:0]  stop_bit,
  input  logic        rx_ready,
  input  logic        overrun_clr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  rx_state_e              state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [31:0]            baud_cnt;
  logic [31:0]            div_q;
  logic                   tick;
  logic [3:0]             os_cnt, os_cnt_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             shift_q, shift_n;
  logic                   second_q, second_n;
  logic                   push;
  logic                   fe_n;
  logic                   pop;
  logic                   fifo_full;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign busy = (state != IDLE);
  assign pop  = rx_valid && rx_ready;

  // Metastability synchronizer for the asynchronous serial line, idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  // Oversample tick; the divisor is latched on reload so a change applies from the next period.
  always_comb begin
    tick = (state != IDLE) && ((div_q <= 32'd1) || (baud_cnt >= div_q - 32'd1));
  end

  // Tick counter, held at zero while idle so frame timing starts at start-bit detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      div_q    <= '0;
    end else if ((state == IDLE) || tick) begin
      baud_cnt <= '0;
      div_q    <= baud_divisor;
    end else begin
      baud_cnt <= baud_cnt + 32'd1;
    end
  end

  // Frame FSM next-state: start validation, LSB-first data capture, one or two stop bits.
  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    second_n  = second_q;
    push      = 1'b0;
    fe_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          os_cnt_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == 4'(HALF_BIT - 1)) begin
            os_cnt_n = '0;
            if (!rx_s) begin
              state_n   = DATA;
              bit_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            os_cnt_n = os_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_cnt_n = os_cnt + 4'd1;
          if (os_cnt == 4'(OVERSAMPLE - 1)) begin
            shift_n   = {rx_s, shift_q[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state_n  = STOP;
              second_n = 1'b0;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_cnt_n = os_cnt + 4'd1;
          if (os_cnt == 4'(OVERSAMPLE - 1)) begin
            if (!rx_s) begin
              fe_n    = 1'b1;
              state_n = IDLE;
            end else if ((stop_bit == 2'b10) && !second_q) begin
              second_n = 1'b1;
            end else begin
              push    = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      second_q  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_q   <= shift_n;
      second_q  <= second_n;
      frame_err <= fe_n;
    end
  end

  // Sticky overrun: a good byte lost to a full FIFO; a new overrun beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (shift_q),
    .pop     (rx_ready),
    .head    (rx_data),
    .valid   (rx_valid),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_in;
  logic [31:0] baud_divisor;
  logic [1:0]  stop_bit;
  logic        rx_ready;
  logic        overrun_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int fe_cnt;
  int valid_cycles;
  logic [7:0] got_q[$];

  uart_rx_core #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .baud_divisor (baud_divisor),
    .stop_bit     (stop_bit),
    .rx_ready     (rx_ready),
    .overrun_clr  (overrun_clr),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Observe accepted bytes, frame_err cycles and valid cycles away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (rx_valid) valid_cycles++;
    end
  end

  function automatic int bclks();
    return 16 * ((baud_divisor <= 32'd1) ? 1 : int'(baud_divisor));
  endfunction

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transmit one frame: start, 8 data bits LSB first, one or two stop levels, then idle.
  task automatic send_frame(input logic [7:0] b, input int nst, input logic s1, input logic s2);
    int bt;
    bt = bclks();
    hold(1'b0, bt);
    for (int i = 0; i < 8; i++) hold(b[i], bt);
    hold(s1, bt);
    if (nst == 2) hold(s2, bt);
    hold(1'b1, 2 * bt);
  endtask

  task automatic clear_obs();
    got_q.delete();
    fe_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; baud_divisor = 32'd4; stop_bit = 2'b01;
    rx_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h exp=00", rx_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%0b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%0b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    reset = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_basic();
    rx_ready = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1, 1'b1, 1'b1);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%02h exp=a5", got_q[0]); end
    end
    total++; if (valid_cycles != 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles); end
    total++; if (fe_cnt != 0) begin bad++; $display("FAIL basic_fe got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_glitch();
    clear_obs();
    hold(1'b0, 20);
    hold(1'b1, 100);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%0b exp=0", busy); end
    total++; if (got_q.size() != 0 || rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_data got=%0d/%0b exp=0/0", got_q.size(), rx_valid); end
    total++; if (fe_cnt != 0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'h3C, 1, 1'b0, 1'b1);
    total++; if (fe_cnt != 1) begin bad++; $display("FAIL fe_pulse got=%0d exp=1", fe_cnt); end
    total++; if (got_q.size() != 0 || rx_valid !== 1'b0) begin bad++; $display("FAIL fe_nopush got=%0d/%0b exp=0/0", got_q.size(), rx_valid); end
    clear_obs();
    send_frame(8'h5A, 1, 1'b1, 1'b1);
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin bad++; $display("FAIL fe_recover got=%0d bytes exp=1 byte 5a", got_q.size()); end
    total++; if (fe_cnt != 0) begin bad++; $display("FAIL fe_recover_fe got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_two_stop();
    stop_bit = 2'b10;
    clear_obs();
    send_frame(8'h81, 2, 1'b1, 1'b0);
    total++; if (fe_cnt != 1) begin bad++; $display("FAIL stop2_fe got=%0d exp=1", fe_cnt); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL stop2_nopush got=%0d exp=0", got_q.size()); end
    clear_obs();
    send_frame(8'h81, 2, 1'b1, 1'b1);
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h81 || fe_cnt != 0) begin bad++; $display("FAIL stop2_good got=%0d bytes fe=%0d exp=1 byte 81 fe=0", got_q.size(), fe_cnt); end
    stop_bit = 2'b01;
  endtask

  task automatic test_overrun();
    logic [7:0] mq[$];
    logic exp_ovr;
    exp_ovr = 1'b0;
    rx_ready = 1'b0;
    clear_obs();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1, 1'b1, 1'b1);
      if (mq.size() < 4) mq.push_back(8'(k));
      else exp_ovr = 1'b1;
    end
    total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL ovr_set got=%0b exp=%0b", overrun, exp_ovr); end
    total++; if (rx_valid !== 1'b1 || rx_data !== mq[0]) begin bad++; $display("FAIL ovr_head got=%0b/%02h exp=1/%02h", rx_valid, rx_data, mq[0]); end
    for (int k = 0; k < 6; k++) begin
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      hold(1'b1, 3);
    end
    total++; if (got_q.size() != mq.size()) begin bad++; $display("FAIL ovr_pop_count got=%0d exp=%0d", got_q.size(), mq.size()); end
    for (int k = 0; k < mq.size() && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== mq[k]) begin bad++; $display("FAIL ovr_pop_%0d got=%02h exp=%02h", k, got_q[k], mq[k]); end
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got=%0b exp=0", rx_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
  endtask

  task automatic test_reset_mid();
    int bt;
    rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1, 1'b1, 1'b1);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_preload got=%0b exp=1", rx_valid); end
    bt = bclks();
    hold(1'b0, bt);
    for (int i = 0; i < 3; i++) hold(1'b1, bt);
    hold(1'b1, bt / 2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%0b exp=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0)
      begin bad++; $display("FAIL rstmid_outputs got busy=%0b valid=%0b data=%02h fe=%0b ovr=%0b exp all 0", busy, rx_valid, rx_data, frame_err, overrun); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 5 * bt);
    total++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after got valid=%0b busy=%0b exp=0/0", rx_valid, busy); end
    rx_ready = 1'b1;
    clear_obs();
    send_frame(8'h42, 1, 1'b1, 1'b1);
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h42) begin bad++; $display("FAIL rstmid_next got=%0d bytes exp=1 byte 42", got_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int nst;
    int divs[6] = '{1, 2, 3, 4, 6, 8};
    rx_ready = 1'b1;
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      baud_divisor = 32'(divs[$urandom_range(0, 5)]);
      stop_bit = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      nst = (stop_bit == 2'b10) ? 2 : 1;
      hold(1'b1, 4);
      send_frame(b, nst, 1'b1, 1'b1);
      exp_q.push_back(b);
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand_byte_%0d got=%02h exp=%02h", k, got_q[k], exp_q[k]); end
    end
    total++; if (fe_cnt != 0) begin bad++; $display("FAIL rand_fe got=%0d exp=0", fe_cnt); end
    baud_divisor = 32'd4;
    stop_bit = 2'b01;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_two_stop();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
